lsu_bus_ctrl: RTL and testbench

//  Load/store unit stage directly downstream of the dual-issue AGU.

---
 rtl/lsu_bus_ctrl_pkg.sv | 36 +++
 rtl/lsu_bus_ctrl_if.sv | 16 +
 rtl/lsu_bus_ctrl_pend_fifo.sv | 61 ++++++
 rtl/lsu_bus_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_bus_ctrl_pkg.sv
// rtl/lsu_bus_ctrl_pkg.sv - shared types and load-extraction helper for the LSU bus controller
package lsu_bus_ctrl_pkg;

   localparam int COMMIT_ID_W = 4;
   localparam int REG_ADDR_W  = 5;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

   // One granted-but-unreturned load: everything needed to build its writeback.
   typedef struct packed {
      logic [REG_ADDR_W-1:0]  rd;
      logic [COMMIT_ID_W-1:0] cid;
      logic [2:0]             off;
      lsu_size_e              size;
      logic                   sext;
      logic                   killed;
   } lsu_pend_t;

   // Pick the addressed byte/half/word out of the 64-bit beat and extend it.
   function automatic logic [31:0] lsu_extract(input logic [63:0] rdata, input lsu_pend_t e);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] w;
      logic [31:0] res;
      b = rdata[{e.off, 3'b000} +: 8];
      h = rdata[{e.off[2:1], 4'b0000} +: 16];
      w = rdata[{e.off[2], 5'b00000} +: 32];
      case (e.size)
         SZ_B:    res = {{24{e.sext & b[7]}}, b};
         SZ_H:    res = {{16{e.sext & h[15]}}, h};
         default: res = w;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// rtl/lsu_bus_ctrl_if.sv - 64-bit req/gnt/rvalid memory bus between LSU and memory
interface lsu_bus_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        wmask;
   logic [63:0]       wdata;
   logic              gnt;
   logic              rvalid;
   logic [63:0]       rdata;

   modport master (output req, we, addr, wmask, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wmask, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_bus_ctrl_pend_fifo.sv
// rtl/lsu_bus_ctrl_pend_fifo.sv - in-order queue of outstanding loads with kill-all
module lsu_bus_ctrl_pend_fifo
   import lsu_bus_ctrl_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  lsu_pend_t     push_data,
   input  logic          pop,
   output lsu_pend_t     pop_data,
   input  logic          kill_all,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   lsu_pend_t       mem [DEPTH];
   logic [PW-1:0]   wptr;
   logic [PW-1:0]   rptr;
   logic            do_push;
   logic            do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rptr];

   // Storage, pointers and occupancy; a push in the kill cycle carries its own killed bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (kill_all) begin
            for (int i = 0; i < DEPTH; i++) mem[i].killed <= 1'b1;
         end
         if (do_push) begin
            mem[wptr] <= push_data;
            wptr      <= next_ptr(wptr);
         end
         if (do_pop) rptr <= next_ptr(rptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// rtl/lsu_bus_ctrl.sv - LSU stage: AGU access to memory bus, load tracking and writeback
module lsu_bus_ctrl
   import lsu_bus_ctrl_pkg::*;
#(
   parameter int OUTSTANDING = 2,
   parameter int ADDR_W      = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   input  logic                   agu_req_i,
   input  logic [ADDR_W-1:0]      agu_addr_i,
   input  logic [7:0]             agu_wmask_i,
   input  logic [63:0]            agu_wdata_i,
   input  logic [COMMIT_ID_W-1:0] agu_commit_id_i,
   input  logic [REG_ADDR_W-1:0]  agu_rd_i,
   input  logic                   agu_op_lb_i,
   input  logic                   agu_op_lh_i,
   input  logic                   agu_op_lw_i,
   input  logic                   agu_op_lbu_i,
   input  logic                   agu_op_lhu_i,
   input  logic                   agu_load_i,
   input  logic                   agu_store_i,
   input  logic                   agu_mis_ld_i,
   input  logic                   agu_mis_st_i,
   output logic                   lsu_stall_o,
   lsu_bus_ctrl_if.master         mem,
   output logic                   wb_valid_o,
   output logic [REG_ADDR_W-1:0]  wb_rd_o,
   output logic [31:0]            wb_data_o,
   output logic [COMMIT_ID_W-1:0] wb_commit_id_o,
   output logic                   st_done_o,
   output logic [COMMIT_ID_W-1:0] st_commit_id_o,
   output logic                   exc_valid_o,
   output logic                   exc_is_load_o,
   output logic [ADDR_W-1:0]      exc_addr_o,
   output logic [COMMIT_ID_W-1:0] exc_commit_id_o
);
   localparam int CW = $clog2(OUTSTANDING + 1);

   typedef enum logic {ST_IDLE, ST_REQ} req_state_e;

   req_state_e             state;
   logic                   req_we;
   logic [ADDR_W-1:0]      req_addr;
   logic [7:0]             req_wmask;
   logic [63:0]            req_wdata;
   logic [COMMIT_ID_W-1:0] req_cid;
   logic [REG_ADDR_W-1:0]  req_rd;
   lsu_size_e              req_size;
   logic                   req_sext;

   lsu_size_e              agu_size;
   logic                   agu_sext;
   logic                   misaligned;
   logic                   accept;
   logic                   acc_aligned;
   logic                   acc_mis;
   logic                   grant;

   lsu_pend_t              push_entry;
   lsu_pend_t              head;
   logic [CW-1:0]          pend_count;
   logic                   pend_full;
   logic                   pend_empty;
   logic                   pop_ok;

   // Load size and signedness from the one-hot op bits.
   always_comb begin
      agu_size = SZ_W;
      if (agu_op_lw_i)                     agu_size = SZ_W;
      else if (agu_op_lh_i || agu_op_lhu_i) agu_size = SZ_H;
      else if (agu_op_lb_i || agu_op_lbu_i) agu_size = SZ_B;
      agu_sext = agu_op_lb_i || agu_op_lh_i;
   end

   assign misaligned  = (agu_load_i && agu_mis_ld_i) || (agu_store_i && agu_mis_st_i);
   assign accept      = agu_req_i && (agu_load_i || agu_store_i) && !lsu_stall_o && !flush_i;
   assign acc_aligned = accept && !misaligned;
   assign acc_mis     = accept && misaligned;

   // A load may not go out while every tracking slot is occupied.
   assign mem.req   = (state == ST_REQ) && (req_we || !pend_full);
   assign mem.we    = req_we;
   assign mem.addr  = {req_addr[ADDR_W-1:3], 3'b000};
   assign mem.wmask = req_wmask;
   assign mem.wdata = req_wdata;
   assign grant     = mem.req && mem.gnt;

   assign lsu_stall_o = ((state == ST_REQ) && !grant) || (pend_count == CW'(OUTSTANDING));

   assign push_entry = '{rd: req_rd, cid: req_cid, off: req_addr[2:0],
                         size: req_size, sext: req_sext, killed: flush_i};
   assign pop_ok     = mem.rvalid && !pend_empty;

   lsu_bus_ctrl_pend_fifo #(.DEPTH(OUTSTANDING)) u_pend (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (grant && !req_we),
      .push_data (push_entry),
      .pop       (mem.rvalid),
      .pop_data  (head),
      .kill_all  (flush_i),
      .count     (pend_count),
      .full      (pend_full),
      .empty     (pend_empty)
   );

   // Request FSM: the request register holds the bus access until it is granted or flushed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         req_we    <= 1'b0;
         req_addr  <= '0;
         req_wmask <= '0;
         req_wdata <= '0;
         req_cid   <= '0;
         req_rd    <= '0;
         req_size  <= SZ_B;
         req_sext  <= 1'b0;
      end else if (acc_aligned) begin
         state     <= ST_REQ;
         req_we    <= agu_store_i;
         req_addr  <= agu_addr_i;
         req_wmask <= agu_store_i ? agu_wmask_i : 8'h00;
         req_wdata <= agu_wdata_i;
         req_cid   <= agu_commit_id_i;
         req_rd    <= agu_rd_i;
         req_size  <= agu_size;
         req_sext  <= agu_sext;
      end else if (grant || flush_i) begin
         state <= ST_IDLE;
      end
   end

   // Registered writeback, store-done and exception pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_o      <= 1'b0;
         wb_rd_o         <= '0;
         wb_data_o       <= '0;
         wb_commit_id_o  <= '0;
         st_done_o       <= 1'b0;
         st_commit_id_o  <= '0;
         exc_valid_o     <= 1'b0;
         exc_is_load_o   <= 1'b0;
         exc_addr_o      <= '0;
         exc_commit_id_o <= '0;
      end else begin
         wb_valid_o <= pop_ok && !head.killed && !flush_i;
         if (pop_ok && !head.killed && !flush_i) begin
            wb_rd_o        <= head.rd;
            wb_data_o      <= lsu_extract(mem.rdata, head);
            wb_commit_id_o <= head.cid;
         end
         st_done_o <= grant && req_we;
         if (grant && req_we) st_commit_id_o <= req_cid;
         exc_valid_o <= acc_mis;
         if (acc_mis) begin
            exc_is_load_o   <= agu_load_i;
            exc_addr_o      <= agu_addr_i;
            exc_commit_id_o <= agu_commit_id_i;
         end
      end
   end

   // Read data must always belong to a tracked load.
   assert property (@(posedge clk) disable iff (!rst_n) mem.rvalid |-> !pend_empty)
      else $error("lsu_bus_ctrl: rvalid with no outstanding load");

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb/tb_lsu_bus_ctrl.sv - self-checking bench for lsu_bus_ctrl
module tb_lsu_bus_ctrl;
   import lsu_bus_ctrl_pkg::*;

   localparam int K_LB = 0, K_LH = 1, K_LW = 2, K_LBU = 3, K_LHU = 4;

   logic clk = 1'b0;
   logic rst_n, flush_i, agu_req_i;
   logic [31:0] agu_addr_i;
   logic [7:0] agu_wmask_i;
   logic [63:0] agu_wdata_i;
   logic [COMMIT_ID_W-1:0] agu_commit_id_i;
   logic [REG_ADDR_W-1:0] agu_rd_i;
   logic op_lb, op_lh, op_lw, op_lbu, op_lhu, agu_load_i, agu_store_i, mis_ld, mis_st;
   logic lsu_stall_o, wb_valid_o, st_done_o, exc_valid_o, exc_is_load_o;
   logic [REG_ADDR_W-1:0] wb_rd_o;
   logic [31:0] wb_data_o, exc_addr_o;
   logic [COMMIT_ID_W-1:0] wb_commit_id_o, st_commit_id_o, exc_commit_id_o;
   int n_checks = 0;
   int n_fail = 0;

   lsu_bus_ctrl_if #(.ADDR_W(32)) bus ();

   lsu_bus_ctrl #(.OUTSTANDING(2), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .agu_req_i(agu_req_i),
      .agu_addr_i(agu_addr_i), .agu_wmask_i(agu_wmask_i), .agu_wdata_i(agu_wdata_i),
      .agu_commit_id_i(agu_commit_id_i), .agu_rd_i(agu_rd_i),
      .agu_op_lb_i(op_lb), .agu_op_lh_i(op_lh), .agu_op_lw_i(op_lw),
      .agu_op_lbu_i(op_lbu), .agu_op_lhu_i(op_lhu),
      .agu_load_i(agu_load_i), .agu_store_i(agu_store_i),
      .agu_mis_ld_i(mis_ld), .agu_mis_st_i(mis_st),
      .lsu_stall_o(lsu_stall_o), .mem(bus),
      .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
      .wb_commit_id_o(wb_commit_id_o), .st_done_o(st_done_o), .st_commit_id_o(st_commit_id_o),
      .exc_valid_o(exc_valid_o), .exc_is_load_o(exc_is_load_o), .exc_addr_o(exc_addr_o),
      .exc_commit_id_o(exc_commit_id_o)
   );

   always #5 clk = ~clk;

   // Reference: shift the beat right to the addressed lane, mask, then extend.
   function automatic logic [31:0] ref_load(input int kind, input logic [31:0] addr, input logic [63:0] rdata);
      int off;
      logic [63:0] s;
      logic [31:0] v;
      off = int'(addr[2:0]);
      if (kind == K_LB || kind == K_LBU) begin
         s = rdata >> (8 * off);
         v = s[31:0] & 32'h0000_00FF;
         if (kind == K_LB && v[7]) v = v | 32'hFFFF_FF00;
      end else if (kind == K_LH || kind == K_LHU) begin
         s = rdata >> (8 * (off & 6));
         v = s[31:0] & 32'h0000_FFFF;
         if (kind == K_LH && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         s = rdata >> (8 * (off & 4));
         v = s[31:0];
      end
      return v;
   endfunction

   task automatic idle_agu();
      agu_req_i = 0; agu_addr_i = 0; agu_wmask_i = 0; agu_wdata_i = 0;
      agu_commit_id_i = 0; agu_rd_i = 0; op_lb = 0; op_lh = 0; op_lw = 0; op_lbu = 0; op_lhu = 0;
      agu_load_i = 0; agu_store_i = 0; mis_ld = 0; mis_st = 0;
   endtask

   task automatic drive_load(input int kind, input logic [31:0] addr, input logic mis,
                             input logic [REG_ADDR_W-1:0] rd, input logic [COMMIT_ID_W-1:0] cid);
      idle_agu();
      agu_req_i = 1; agu_load_i = 1; agu_addr_i = addr; mis_ld = mis; agu_rd_i = rd; agu_commit_id_i = cid;
      op_lb = (kind == K_LB); op_lh = (kind == K_LH); op_lw = (kind == K_LW);
      op_lbu = (kind == K_LBU); op_lhu = (kind == K_LHU);
   endtask

   task automatic drive_store(input logic [31:0] addr, input logic [7:0] wmask, input logic [63:0] wdata,
                              input logic mis, input logic [COMMIT_ID_W-1:0] cid);
      idle_agu();
      agu_req_i = 1; agu_store_i = 1; agu_addr_i = addr; agu_wmask_i = wmask;
      agu_wdata_i = wdata; mis_st = mis; agu_commit_id_i = cid;
   endtask

   // Waits (bounded) for the AGU access to be taken, then idles the AGU.
   task automatic accept();
      int n;
      n = 0;
      while (lsu_stall_o === 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin n_checks++; n_fail++; $display("FAIL accept_timeout: stall=%0b after %0d cycles, want 0", lsu_stall_o, n); end
      @(negedge clk);
      idle_agu();
   endtask

   task automatic do_load(input int kind, input logic [31:0] addr, input logic [REG_ADDR_W-1:0] rd,
                          input logic [COMMIT_ID_W-1:0] cid, input logic [63:0] rdata,
                          input int gdel, input int rdel, input logic [31:0] exp_data);
      drive_load(kind, addr, 1'b0, rd, cid);
      accept();
      n_checks++; if (bus.req !== 1'b1 || bus.we !== 1'b0 || bus.addr !== (addr & ~32'h7)) begin
         n_fail++; $display("FAIL ld_bus: req=%0b we=%0b addr=%h, want 1 0 %h", bus.req, bus.we, bus.addr, addr & ~32'h7); end
      for (int i = 0; i < gdel; i++) begin
         n_checks++; if (bus.req !== 1'b1 || lsu_stall_o !== 1'b1 || bus.addr !== (addr & ~32'h7)) begin
            n_fail++; $display("FAIL ld_hold: req=%0b stall=%0b addr=%h, want 1 1 %h", bus.req, lsu_stall_o, bus.addr, addr & ~32'h7); end
         @(negedge clk);
      end
      bus.gnt = 1; @(negedge clk); bus.gnt = 0;
      n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL ld_req_drop: req=%0b want 0", bus.req); end
      for (int i = 0; i < rdel; i++) begin
         n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL ld_early_wb: wb_valid=%0b want 0", wb_valid_o); end
         @(negedge clk);
      end
      bus.rvalid = 1; bus.rdata = rdata; @(negedge clk); bus.rvalid = 0;
      n_checks++; if (wb_valid_o !== 1'b1 || wb_data_o !== exp_data || wb_rd_o !== rd || wb_commit_id_o !== cid) begin
         n_fail++; $display("FAIL ld_wb: valid=%0b data=%h rd=%0d cid=%0d, want 1 %h %0d %0d",
                            wb_valid_o, wb_data_o, wb_rd_o, wb_commit_id_o, exp_data, rd, cid); end
      @(negedge clk);
      n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL ld_wb_pulse: wb_valid=%0b want 0", wb_valid_o); end
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [7:0] wmask, input logic [63:0] wdata,
                           input logic [COMMIT_ID_W-1:0] cid, input int gdel);
      drive_store(addr, wmask, wdata, 1'b0, cid);
      accept();
      for (int i = 0; i <= gdel; i++) begin
         n_checks++; if (bus.req !== 1'b1 || bus.we !== 1'b1 || bus.addr !== (addr & ~32'h7) ||
                          bus.wmask !== wmask || bus.wdata !== wdata || st_done_o !== 1'b0) begin
            n_fail++; $display("FAIL st_hold: req=%0b we=%0b addr=%h mask=%h data=%h done=%0b, want 1 1 %h %h %h 0",
                               bus.req, bus.we, bus.addr, bus.wmask, bus.wdata, st_done_o, addr & ~32'h7, wmask, wdata); end
         n_checks++; if (lsu_stall_o !== 1'b1) begin n_fail++; $display("FAIL st_stall: stall=%0b want 1", lsu_stall_o); end
         if (i < gdel) @(negedge clk);
      end
      bus.gnt = 1; @(negedge clk); bus.gnt = 0;
      n_checks++; if (st_done_o !== 1'b1 || st_commit_id_o !== cid || bus.req !== 1'b0) begin
         n_fail++; $display("FAIL st_done: done=%0b cid=%0d req=%0b, want 1 %0d 0", st_done_o, st_commit_id_o, bus.req, cid); end
      @(negedge clk);
      n_checks++; if (st_done_o !== 1'b0) begin n_fail++; $display("FAIL st_done_pulse: done=%0b want 0", st_done_o); end
   endtask

   task automatic test_reset();
      n_checks++; if (bus.req !== 1'b0 || lsu_stall_o !== 1'b0 || wb_valid_o !== 1'b0 || st_done_o !== 1'b0 ||
                       exc_valid_o !== 1'b0 || wb_data_o !== 32'h0) begin
         n_fail++; $display("FAIL reset_outputs: req=%0b stall=%0b wb=%0b st=%0b exc=%0b data=%h, want all 0",
                            bus.req, lsu_stall_o, wb_valid_o, st_done_o, exc_valid_o, wb_data_o); end
      rst_n = 1; @(negedge clk);
      n_checks++; if (bus.req !== 1'b0 || lsu_stall_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: req=%0b stall=%0b want 0 0", bus.req, lsu_stall_o); end
   endtask

   task automatic test_lw();
      do_load(K_LW, 32'h1004, 5'd5, 4'd3, 64'hAABBCCDD_11223344, 0, 1, 32'hAABBCCDD);
   endtask

   task automatic test_lb_lbu();
      do_load(K_LB, 32'h1007, 5'd7, 4'd4, 64'h80112233_44556677, 1, 0, 32'hFFFFFF80);
      do_load(K_LBU, 32'h1007, 5'd8, 4'd5, 64'h80112233_44556677, 0, 2, 32'h00000080);
   endtask

   task automatic test_store_wait();
      do_store(32'h2000, 8'h0F, 64'h01234567_89ABCDEF, 4'd9, 3);
   endtask

   task automatic test_outstanding();
      logic [63:0] r [3];
      logic [31:0] a [3];
      a[0] = 32'h5000; a[1] = 32'h5008; a[2] = 32'h5014;
      for (int i = 0; i < 3; i++) r[i] = {$urandom, $urandom};
      bus.gnt = 1;
      for (int i = 0; i < 3; i++) begin
         drive_load(K_LW, a[i], 1'b0, 5'(10 + i), 4'(i + 1));
         n_checks++; if (lsu_stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_%0d: stall=%0b want 0", i, lsu_stall_o); end
         @(negedge clk);
      end
      idle_agu();
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (bus.req !== 1'b0 || lsu_stall_o !== 1'b1) begin
            n_fail++; $display("FAIL third_held: req=%0b stall=%0b want 0 1", bus.req, lsu_stall_o); end
         @(negedge clk);
      end
      bus.rvalid = 1; bus.rdata = r[0]; @(negedge clk); bus.rvalid = 0;
      n_checks++; if (wb_valid_o !== 1'b1 || wb_data_o !== ref_load(K_LW, a[0], r[0]) || wb_rd_o !== 5'd10) begin
         n_fail++; $display("FAIL b2b_wb0: valid=%0b data=%h rd=%0d want 1 %h 10", wb_valid_o, wb_data_o, wb_rd_o, ref_load(K_LW, a[0], r[0])); end
      n_checks++; if (bus.req !== 1'b1 || lsu_stall_o !== 1'b0) begin
         n_fail++; $display("FAIL third_release: req=%0b stall=%0b want 1 0", bus.req, lsu_stall_o); end
      @(negedge clk); bus.gnt = 0;
      for (int i = 1; i < 3; i++) begin
         bus.rvalid = 1; bus.rdata = r[i]; @(negedge clk); bus.rvalid = 0;
         n_checks++; if (wb_valid_o !== 1'b1 || wb_data_o !== ref_load(K_LW, a[i], r[i]) ||
                          wb_rd_o !== 5'(10 + i) || wb_commit_id_o !== 4'(i + 1)) begin
            n_fail++; $display("FAIL b2b_wb%0d: valid=%0b data=%h rd=%0d cid=%0d want 1 %h %0d %0d", i, wb_valid_o,
                               wb_data_o, wb_rd_o, wb_commit_id_o, ref_load(K_LW, a[i], r[i]), 10 + i, i + 1); end
      end
      @(negedge clk);
   endtask

   task automatic test_misaligned();
      drive_load(K_LH, 32'h3001, 1'b1, 5'd2, 4'd6);
      accept();
      n_checks++; if (exc_valid_o !== 1'b1 || exc_is_load_o !== 1'b1 || exc_addr_o !== 32'h3001 ||
                       exc_commit_id_o !== 4'd6 || bus.req !== 1'b0 || lsu_stall_o !== 1'b0) begin
         n_fail++; $display("FAIL mis_ld: exc=%0b ld=%0b addr=%h cid=%0d req=%0b stall=%0b want 1 1 3001 6 0 0",
                            exc_valid_o, exc_is_load_o, exc_addr_o, exc_commit_id_o, bus.req, lsu_stall_o); end
      @(negedge clk);
      n_checks++; if (exc_valid_o !== 1'b0 || bus.req !== 1'b0) begin
         n_fail++; $display("FAIL mis_pulse: exc=%0b req=%0b want 0 0", exc_valid_o, bus.req); end
      drive_store(32'h2002, 8'h0C, 64'h0, 1'b1, 4'd11);
      accept();
      n_checks++; if (exc_valid_o !== 1'b1 || exc_is_load_o !== 1'b0 || exc_addr_o !== 32'h2002 || bus.req !== 1'b0) begin
         n_fail++; $display("FAIL mis_st: exc=%0b ld=%0b addr=%h req=%0b want 1 0 2002 0",
                            exc_valid_o, exc_is_load_o, exc_addr_o, bus.req); end
      @(negedge clk);
   endtask

   task automatic flush_drain(input string tag);
      for (int i = 0; i < 2; i++) begin
         bus.rvalid = 1; bus.rdata = {$urandom, $urandom}; @(negedge clk); bus.rvalid = 0;
         n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL %s_killed_wb%0d: wb_valid=%0b want 0", tag, i, wb_valid_o); end
      end
      @(negedge clk);
      n_checks++; if (wb_valid_o !== 1'b0 || lsu_stall_o !== 1'b0) begin
         n_fail++; $display("FAIL %s_drained: wb=%0b stall=%0b want 0 0", tag, wb_valid_o, lsu_stall_o); end
   endtask

   task automatic test_flush();
      // both loads already queued when the flush hits
      bus.gnt = 1;
      drive_load(K_LW, 32'h6000, 1'b0, 5'd1, 4'd1); @(negedge clk);
      drive_load(K_LW, 32'h6008, 1'b0, 5'd2, 4'd2); @(negedge clk);
      idle_agu(); @(negedge clk); bus.gnt = 0;
      n_checks++; if (bus.req !== 1'b0 || lsu_stall_o !== 1'b1) begin
         n_fail++; $display("FAIL flushq_full: req=%0b stall=%0b want 0 1", bus.req, lsu_stall_o); end
      flush_i = 1; @(negedge clk); flush_i = 0;
      flush_drain("flushq");
      // second load granted in the very cycle of the flush
      bus.gnt = 1;
      drive_load(K_LH, 32'h6102, 1'b0, 5'd3, 4'd3); @(negedge clk);
      drive_load(K_LB, 32'h6105, 1'b0, 5'd4, 4'd4); @(negedge clk);
      idle_agu(); flush_i = 1; @(negedge clk); flush_i = 0; bus.gnt = 0;
      n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL flushg_req: req=%0b want 0", bus.req); end
      flush_drain("flushg");
      // flush while a load waits for grant
      drive_load(K_LW, 32'h6200, 1'b0, 5'd5, 4'd5); accept();
      flush_i = 1; @(negedge clk); flush_i = 0;
      n_checks++; if (bus.req !== 1'b0 || lsu_stall_o !== 1'b0) begin
         n_fail++; $display("FAIL flushr: req=%0b stall=%0b want 0 0", bus.req, lsu_stall_o); end
      // flush beats a simultaneous accept
      drive_load(K_LW, 32'h6300, 1'b0, 5'd6, 4'd6); flush_i = 1; @(negedge clk); flush_i = 0; idle_agu();
      n_checks++; if (bus.req !== 1'b0 || exc_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL flush_vs_accept: req=%0b exc=%0b want 0 0", bus.req, exc_valid_o); end
      @(negedge clk);
      do_load(K_LHU, 32'h6406, 5'd9, 4'd9, 64'hFEDC0000_00000000, 0, 0, 32'h0000FEDC);
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         int kind;
         logic [31:0] addr;
         logic [63:0] data;
         kind = int'($urandom_range(0, 5));
         addr = $urandom & 32'h0000_FFFF;
         data = {$urandom, $urandom};
         if (kind == 5) begin
            do_store(addr, 8'($urandom), data, 4'($urandom), int'($urandom_range(0, 3)));
         end else begin
            if (kind == K_LH || kind == K_LHU) addr[0] = 1'b0;
            if (kind == K_LW) addr[1:0] = 2'b00;
            do_load(kind, addr, 5'($urandom), 4'($urandom), data, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), ref_load(kind, addr, data));
         end
      end
   endtask

   task automatic test_reset_mid();
      bus.gnt = 1;
      drive_load(K_LW, 32'h7000, 1'b0, 5'd20, 4'd12); accept(); @(negedge clk); bus.gnt = 0;
      drive_load(K_LW, 32'h7008, 1'b0, 5'd21, 4'd13); accept();
      #2 rst_n = 0;
      #1;
      n_checks++; if (bus.req !== 1'b0 || lsu_stall_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid: req=%0b stall=%0b want 0 0", bus.req, lsu_stall_o); end
      @(negedge clk); rst_n = 1; @(negedge clk);
      do_load(K_LW, 32'h7104, 5'd22, 4'd14, 64'h12345678_9ABCDEF0, 0, 0, 32'h12345678);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; flush_i = 0; idle_agu();
      bus.gnt = 0; bus.rvalid = 0; bus.rdata = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_lw();
      test_lb_lbu();
      test_store_wait();
      test_outstanding();
      test_misaligned();
      test_flush();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
